// File: rtl/alu_result_tx_feeder_pkg.sv
// rtl/alu_result_tx_feeder_pkg.sv - shared widths and feeder state encodings
package alu_result_tx_feeder_pkg;

    localparam int OPERAND_WIDTH      = 16;
    localparam int DEF_RESULT_WIDTH   = 16;
    localparam int DEF_BYTE_WIDTH     = 8;

    typedef enum logic [1:0] {
        FEED_IDLE  = 2'b00,
        FEED_REQ   = 2'b01,
        FEED_DRAIN = 2'b10
    } feed_state_e;

endpackage

// File: rtl/alu_result_tx_feeder_byte_unpacker.sv
// rtl/alu_result_tx_feeder_byte_unpacker.sv - holding buffer, byte shifter and byte counter
module alu_result_tx_feeder_byte_unpacker
    import alu_result_tx_feeder_pkg::*;
#(
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int BYTE_WIDTH   = DEF_BYTE_WIDTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    load,
    input  logic                    shift,
    input  logic                    clear,
    input  logic [RESULT_WIDTH-1:0] load_data,
    output logic [BYTE_WIDTH-1:0]   next_byte,
    output logic                    last_byte
);

    localparam int NUM_BYTES = RESULT_WIDTH / BYTE_WIDTH;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

    logic [RESULT_WIDTH-1:0] hold_q, hold_d, hold_shifted;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    // The byte queued up next is the low byte of the buffer after one shift.
    assign hold_shifted = hold_q >> BYTE_WIDTH;
    assign next_byte    = hold_shifted[BYTE_WIDTH-1:0];
    assign last_byte    = (cnt_q == LAST_IDX);

    // Load restarts the count; shift advances one byte; clear only rewinds the counter.
    always_comb begin
        hold_d = hold_q;
        cnt_d  = cnt_q;
        if (load) begin
            hold_d = load_data;
            cnt_d  = '0;
        end else if (shift) begin
            hold_d = hold_shifted;
            cnt_d  = cnt_q + CNT_W'(1);
        end else if (clear) begin
            cnt_d  = '0;
        end
    end

    // Buffer and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hold_q <= '0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_result_tx_feeder.sv
// rtl/alu_result_tx_feeder.sv - feeds ALU results to UART_TX one byte at a time, LSB first
module alu_result_tx_feeder
    import alu_result_tx_feeder_pkg::*;
#(
    parameter int RESULT_WIDTH = DEF_RESULT_WIDTH,
    parameter int BYTE_WIDTH   = DEF_BYTE_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [RESULT_WIDTH-1:0] ALU_OUT,
    input  logic                    OUT_Valid,
    input  logic                    TX_Busy,
    output logic [BYTE_WIDTH-1:0]   TX_P_DATA,
    output logic                    TX_D_VLD,
    output logic                    Feeder_Busy,
    output logic                    Overrun,
    input  logic                    Clr_Overrun
);

    feed_state_e           state_q, state_d;
    logic [BYTE_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_vld_q, tx_vld_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    logic                  load, shift, clear;
    logic [BYTE_WIDTH-1:0] next_byte;
    logic                  last_byte;

    alu_result_tx_feeder_byte_unpacker #(
        .RESULT_WIDTH (RESULT_WIDTH),
        .BYTE_WIDTH   (BYTE_WIDTH)
    ) u_unpacker (
        .clk       (CLK),
        .resetn    (RST),
        .load      (load),
        .shift     (shift),
        .clear     (clear),
        .load_data (ALU_OUT),
        .next_byte (next_byte),
        .last_byte (last_byte)
    );

    // Next-state and output decode; the first byte is taken straight from ALU_OUT
    // so the request appears one cycle after OUT_Valid.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tx_vld_d  = tx_vld_q;
        busy_d    = busy_q;
        overrun_d = overrun_q;
        load      = 1'b0;
        shift     = 1'b0;
        clear     = 1'b0;

        // Set is applied after clear so a same-cycle collision leaves the flag set.
        if (Clr_Overrun) begin
            overrun_d = 1'b0;
        end
        if (OUT_Valid && (state_q != FEED_IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            FEED_IDLE: begin
                if (OUT_Valid) begin
                    load      = 1'b1;
                    tx_data_d = ALU_OUT[BYTE_WIDTH-1:0];
                    tx_vld_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = FEED_REQ;
                end
            end
            FEED_REQ: begin
                // A busy already high on entry is taken as acceptance of this byte.
                if (TX_Busy) begin
                    tx_vld_d = 1'b0;
                    state_d  = FEED_DRAIN;
                end
            end
            FEED_DRAIN: begin
                if (!TX_Busy) begin
                    if (!last_byte) begin
                        shift     = 1'b1;
                        tx_data_d = next_byte;
                        tx_vld_d  = 1'b1;
                        state_d   = FEED_REQ;
                    end else begin
                        clear   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FEED_IDLE;
                    end
                end
            end
            default: begin
                clear    = 1'b1;
                tx_vld_d = 1'b0;
                busy_d   = 1'b0;
                state_d  = FEED_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transfer in progress.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= FEED_IDLE;
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            tx_vld_q  <= tx_vld_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign TX_P_DATA   = tx_data_q;
    assign TX_D_VLD    = tx_vld_q;
    assign Feeder_Busy = busy_q;
    assign Overrun     = overrun_q;

endmodule
